// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: sequences start, data, optional parity and stop
// bits with an oversampling edge counter, strobes the checker/deserializer
// stages, and reports each frame with a one-cycle valid or error pulse.
module uart_rx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic                      dat_samp_en,
    output logic                      strt_chk_en,
    output logic                      deser_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [3:0]                bit_cnt,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      framing_error
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] p_lat;
    logic                      par_en_lat;
    logic                      par_flag;

    logic [PRESCALE_WIDTH-1:0] p_sel;
    logic [PRESCALE_WIDTH-1:0] s_idx;
    logic [PRESCALE_WIDTH-1:0] w_idx;
    logic [PRESCALE_WIDTH-1:0] s_next;
    logic                      at_s;
    logic                      edge_end;

    // Oversampling indices derived from the latched ratio; unsupported ratios fall back to 8
    always_comb begin
        p_sel = PRESCALE_WIDTH'(8);
        if (Prescale == PRESCALE_WIDTH'(8) || Prescale == PRESCALE_WIDTH'(16) ||
            Prescale == PRESCALE_WIDTH'(32))
            p_sel = Prescale;
        s_idx    = (p_lat >> 1) + PRESCALE_WIDTH'(2);
        w_idx    = p_lat - PRESCALE_WIDTH'(1);
        s_next   = s_idx + PRESCALE_WIDTH'(1);
        at_s     = (edge_cnt == s_idx);
        edge_end = (edge_cnt == w_idx);
    end

    // Strobes decode only registered state and counters
    always_comb begin
        dat_samp_en = (state != IDLE);
        strt_chk_en = (state == START)  && at_s;
        deser_en    = (state == DATA)   && at_s;
        par_chk_en  = (state == PARITY) && at_s;
        stp_chk_en  = (state == STOP)   && at_s;
    end

    // Frame sequencer, counters, configuration latch and result pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            edge_cnt      <= '0;
            bit_cnt       <= '0;
            p_lat         <= '0;
            par_en_lat    <= 1'b0;
            par_flag      <= 1'b0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            if (state != IDLE)
                edge_cnt <= edge_end ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!RX_IN) begin
                        // detection cycle is edge 0 of the start bit
                        state      <= START;
                        edge_cnt   <= PRESCALE_WIDTH'(1);
                        p_lat      <= p_sel;
                        par_en_lat <= PAR_EN;
                        par_flag   <= 1'b0;
                    end
                end
                START: begin
                    bit_cnt <= '0;
                    if (edge_end)
                        state <= strt_glitch ? IDLE : DATA;
                end
                DATA: begin
                    if (edge_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_lat ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (edge_end) begin
                        par_flag <= par_err & par_en_lat;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    // leave mid stop bit so a following start edge is not missed
                    if (edge_cnt == s_next) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        if (par_flag)
                            parity_error <= 1'b1;
                        else if (stp_err)
                            framing_error <= 1'b1;
                        else
                            data_valid <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: a frame-timing model computes every
// output from the cycle offset within the frame; directed frames pin the model
// with literal offsets, then randomized frames run with noisy checker inputs.
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic [PW-1:0] Prescale = 6'd8;
    logic          strt_glitch = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic          dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          data_valid, parity_error, framing_error;

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en), .deser_en(deser_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .edge_cnt(edge_cnt),
        .bit_cnt(bit_cnt), .data_valid(data_valid), .parity_error(parity_error),
        .framing_error(framing_error)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int nprint = 0;
    int cyc = 0;

    // model state
    bit m_busy = 0, m_par = 0, m_pflag = 0, m_dv = 0, m_pe = 0, m_fe = 0;
    int m_t0 = 0, m_p = 8, m_kend = 0;

    // checker-input drive control
    bit noise = 0, f_glitch = 0, f_par = 0, f_stp = 0;

    // event logs relative to the directed frame start
    bit log_on = 0;
    int t0_dir = 0;
    int q_samp[$], q_strt[$], q_deser[$], q_par[$], q_stp[$], q_dv[$], q_pe[$], q_fe[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        q_samp.delete(); q_strt.delete(); q_deser.delete(); q_par.delete();
        q_stp.delete(); q_dv.delete(); q_pe.delete(); q_fe.delete();
    endtask

    // Sends one serial frame; the start edge lands in the current cycle
    task automatic send_frame(input logic [7:0] data, input int presc, input bit pe,
                              input int gap, input bit scramble);
        int p, s;
        p = (presc == 8 || presc == 16 || presc == 32) ? presc : 8;
        s = p / 2 + 2;
        Prescale = PW'(presc);
        PAR_EN   = pe;
        RX_IN    = 1'b0;
        t0_dir   = cyc;
        tick();
        if (scramble) begin
            Prescale = PW'($urandom_range(0, 63));
            PAR_EN   = ~pe;
        end
        repeat (p - 1) tick();
        for (int i = 0; i < DW; i++) begin
            RX_IN = data[i];
            repeat (p) tick();
        end
        if (pe) begin
            RX_IN = ^data;
            repeat (p) tick();
        end
        RX_IN = 1'b1;
        repeat (s + 2 + gap) tick();
    endtask

    // Checker-result inputs: random noise or forced levels
    initial forever begin
        @(posedge CLK);
        #2;
        if (noise) begin
            strt_glitch = ($urandom_range(0, 9) == 0);
            par_err     = 1'($urandom_range(0, 1));
            stp_err     = ($urandom_range(0, 3) == 0);
        end else begin
            strt_glitch = f_glitch;
            par_err     = f_par;
            stp_err     = f_stp;
        end
    end

    // Frame model: tracks where each frame starts and which result it ends with
    always @(posedge CLK) begin
        int k;
        if (RST) begin
            m_busy = 0; m_dv = 0; m_pe = 0; m_fe = 0;
        end else begin
            m_dv = 0; m_pe = 0; m_fe = 0;
            if (m_busy) begin
                k = cyc - m_t0;
                if (k == m_p - 1 && strt_glitch) begin
                    m_busy = 0;
                end else if (k == m_kend) begin
                    m_busy = 0;
                    if (m_pflag) m_pe = 1;
                    else if (stp_err) m_fe = 1;
                    else m_dv = 1;
                end else if (m_par && k == (DW + 2) * m_p - 1) begin
                    m_pflag = par_err;
                end
            end else if (!RX_IN) begin
                m_busy  = 1;
                m_t0    = cyc;
                m_p     = (Prescale == 8 || Prescale == 16 || Prescale == 32) ? int'(Prescale) : 8;
                m_par   = PAR_EN;
                m_pflag = 0;
                m_kend  = (1 + DW + int'(m_par)) * m_p + m_p / 2 + 3;
            end
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison of every output against the model
    always @(negedge CLK) begin
        int k, bitn, e, s;
        logic x_samp, x_strt, x_deser, x_par, x_stp;
        int x_edge, x_bit;
        logic [17:0] act, exp;
        if (cyc > 0) begin
            x_samp = 0; x_strt = 0; x_deser = 0; x_par = 0; x_stp = 0;
            x_edge = 0; x_bit = 0;
            if (!RST && m_busy) begin
                k    = cyc - m_t0;
                bitn = k / m_p;
                e    = k % m_p;
                s    = m_p / 2 + 2;
                x_samp  = 1;
                x_edge  = e;
                x_strt  = (bitn == 0) && (e == s);
                x_deser = (bitn >= 1) && (bitn <= DW) && (e == s);
                x_par   = m_par && (bitn == DW + 1) && (e == s);
                x_stp   = (bitn == DW + 1 + int'(m_par)) && (e == s);
                x_bit   = (bitn >= 1 && bitn <= DW) ? bitn - 1 : 0;
            end
            exp = {x_samp, x_strt, x_deser, x_par, x_stp, PW'(x_edge), 4'(x_bit),
                   !RST && m_dv, !RST && m_pe, !RST && m_fe};
            act = {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, edge_cnt,
                   bit_cnt, data_valid, parity_error, framing_error};
            tests++;
            if (act !== exp) begin
                fails++;
                if (nprint < 30)
                    $display("FAIL cycle_cmp @%0d: got %05h expected %05h", cyc, act, exp);
                nprint++;
            end
        end
    end

    // Event logger for directed literal checks
    always @(negedge CLK) begin
        int k;
        if (log_on) begin
            k = cyc - t0_dir;
            if (dat_samp_en)   q_samp.push_back(k);
            if (strt_chk_en)   q_strt.push_back(k);
            if (deser_en)      q_deser.push_back(k);
            if (par_chk_en)    q_par.push_back(k);
            if (stp_chk_en)    q_stp.push_back(k);
            if (data_valid)    q_dv.push_back(k);
            if (parity_error)  q_pe.push_back(k);
            if (framing_error) q_fe.push_back(k);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int presc_tab[8];
        presc_tab = '{8, 16, 32, 8, 16, 32, 12, 0};
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_edge_cnt", int'(edge_cnt), 0);
        chk("rst_bit_cnt", int'(bit_cnt), 0);
        chk("rst_outputs", int'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
                                 data_valid, parity_error, framing_error}), 0);
        RST = 1'b0;
        tick();
        log_on = 1;

        // P=8, no parity, good stop
        clear_logs();
        send_frame(8'hA5, 8, 0, 4, 0);
        chk("t1_strt_n", q_strt.size(), 1);
        chk("t1_strt_at", qat(q_strt, 0), 6);
        chk("t1_deser_n", q_deser.size(), 8);
        for (int i = 0; i < 8; i++) chk("t1_deser_at", qat(q_deser, i), 14 + 8 * i);
        chk("t1_stp_at", qat(q_stp, 0), 78);
        chk("t1_par_n", q_par.size(), 0);
        chk("t1_dv_n", q_dv.size(), 1);
        chk("t1_dv_at", qat(q_dv, 0), 80);
        chk("t1_err_n", q_pe.size() + q_fe.size(), 0);

        // P=16, parity enabled, parity checker reports error
        f_par = 1;
        tick();
        clear_logs();
        send_frame(8'h3C, 16, 1, 4, 0);
        f_par = 0;
        chk("t2_par_n", q_par.size(), 1);
        chk("t2_par_at", qat(q_par, 0), 154);
        chk("t2_pe_at", qat(q_pe, 0), 172);
        chk("t2_pe_n", q_pe.size(), 1);
        chk("t2_dv_fe_n", q_dv.size() + q_fe.size(), 0);

        // framing error, next frame one cycle after the pulse
        f_stp = 1;
        tick();
        clear_logs();
        send_frame(8'h5A, 8, 0, 1, 0);
        f_stp = 0;
        chk("t3_fe_at", qat(q_fe, 0), 80);
        chk("t3_fe_n", q_fe.size(), 1);
        chk("t3_dv_n", q_dv.size(), 0);
        clear_logs();
        send_frame(8'hC3, 8, 0, 4, 0);
        chk("t3b_dv_at", qat(q_dv, 0), 80);
        chk("t3b_err_n", q_fe.size() + q_pe.size(), 0);

        // back-to-back: new start on the cycle the previous frame is accepted
        clear_logs();
        send_frame(8'h11, 8, 0, 0, 0);
        send_frame(8'h22, 8, 0, 4, 0);
        chk("t3c_dv_n", q_dv.size(), 2);
        chk("t3c_dv_first", qat(q_dv, 0), 0);
        chk("t3c_dv_second", qat(q_dv, 1), 80);

        // start glitch: RX_IN low for two cycles only
        f_glitch = 1;
        tick();
        clear_logs();
        Prescale = 6'd8;
        PAR_EN = 0;
        RX_IN = 0;
        t0_dir = cyc;
        tick();
        tick();
        RX_IN = 1;
        repeat (20) tick();
        f_glitch = 0;
        chk("t4_samp_n", q_samp.size(), 7);
        chk("t4_samp_last", qat(q_samp, 6), 7);
        chk("t4_strt_at", qat(q_strt, 0), 6);
        chk("t4_strobes_n", q_deser.size() + q_par.size() + q_stp.size(), 0);
        chk("t4_pulses_n", q_dv.size() + q_pe.size() + q_fe.size(), 0);

        // reset during data bit 4
        tick();
        clear_logs();
        RX_IN = 0;
        t0_dir = cyc;
        repeat (8) tick();
        RX_IN = 1;
        repeat (35) tick();
        chk("t5_bit_cnt_before", int'(bit_cnt), 4);
        RST = 1;
        #1;
        chk("t5_rst_outputs", int'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
                                    edge_cnt, bit_cnt, data_valid, parity_error, framing_error}), 0);
        #1;
        repeat (3) tick();
        RST = 0;
        repeat (100) tick();
        chk("t5_pulses_n", q_dv.size() + q_pe.size() + q_fe.size(), 0);
        clear_logs();
        send_frame(8'h96, 8, 0, 4, 0);
        chk("t5_fresh_dv_at", qat(q_dv, 0), 80);

        // unsupported ratio falls back to 8; mid-frame config changes ignored
        clear_logs();
        send_frame(8'h69, 12, 0, 4, 0);
        chk("t6_p12_dv_at", qat(q_dv, 0), 80);
        clear_logs();
        send_frame(8'hF0, 8, 0, 4, 1);
        chk("t6_mid_dv_at", qat(q_dv, 0), 80);
        chk("t6_mid_par_n", q_par.size(), 0);

        // randomized frames with noisy checker results
        log_on = 0;
        noise = 1;
        repeat (40) begin
            int presc;
            presc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63))
                                                : presc_tab[$urandom_range(0, 7)];
            send_frame(8'($urandom), presc, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        noise = 0;
        RX_IN = 1;
        repeat (400) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Control FSM of the UART receiver. It sequences one frame (start, DATA_WIDTH data bits, optional parity, stop) using an internal oversampling edge counter and bit counter.
- It drives the enables of the data sampler, start checker, deserializer, parity checker and stop checker, and consumes their error flags.
- It issues `data_valid` for a clean frame, or a one-cycle error pulse for a bad one.
- It sits between the RX pin synchroniser and the RX checker/deserializer stages, in the UART_RX clock domain.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_WIDTH, 6, width of the Prescale port.

Ports:
- CLK  input  1  UART RX clock; all logic is on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- RX_IN  input  1  synchronised serial line; idles high.
- PAR_EN  input  1  1 = frame carries a parity bit.
- Prescale  input  PRESCALE_WIDTH  oversampling ratio P; supported values are 8, 16, 32.
- strt_glitch  input  1  registered result from the start checker.
- par_err  input  1  registered result from the parity checker.
- stp_err  input  1  registered result from the stop checker; valid one cycle after stp_chk_en.
- dat_samp_en  output  1  enables the data sampler.
- strt_chk_en  output  1  start-check strobe.
- deser_en  output  1  deserializer shift strobe.
- par_chk_en  output  1  parity-check strobe.
- stp_chk_en  output  1  stop-check strobe.
- edge_cnt  output  PRESCALE_WIDTH  current oversample index within the bit.
- bit_cnt  output  4  current data-bit index.
- data_valid  output  1  one-cycle pulse: frame accepted.
- parity_error  output  1  one-cycle pulse: frame dropped for parity.
- framing_error  output  1  one-cycle pulse: frame dropped for stop bit.

Behaviour:
- Reset (async, RST=1):
  - State IDLE, edge_cnt=0, bit_cnt=0.
  - All outputs 0; internal latched P, PAR_EN and parity flag cleared.
  - Reset mid-frame aborts the frame with no pulse emitted.
- Configuration latching:
  - Prescale and PAR_EN are latched on the start-detect cycle and held for the whole frame; mid-frame input changes are ignored.
  - A latched P that is not 8, 16 or 32 is replaced by 8.
- Let S = P/2+2, the sampler output valid index. Let W = P-1, the last edge index of a bit.
- Strobe and counter outputs are combinational decodes of the registered state and counters only; there is no input-to-output path.
- data_valid, parity_error and framing_error are registered.
- States and transitions:
  - IDLE:
    - edge_cnt holds 0.
    - RX_IN=0 → START. That detection cycle counts as edge 0, so edge_cnt=1 on the next cycle.
  - Counting (all non-IDLE states):
    - edge_cnt increments every cycle.
    - edge_cnt wraps W→0 at each bit boundary.
    - dat_samp_en=1.
  - START:
    - strt_chk_en=1 at edge_cnt=S.
    - At edge_cnt=W: if strt_glitch=1 → IDLE with no pulse, otherwise → DATA with bit_cnt=0.
  - DATA:
    - deser_en=1 at edge_cnt=S.
    - At edge_cnt=W: if bit_cnt=DATA_WIDTH-1, bit_cnt←0 and go → PARITY if PAR_EN else → STOP.
    - Otherwise bit_cnt++.
  - PARITY:
    - par_chk_en=1 at edge_cnt=S.
    - At edge_cnt=W, latch par_err into an internal flag, then → STOP unconditionally.
  - STOP:
    - stp_chk_en=1 at edge_cnt=S.
    - At edge_cnt=S+1, evaluate and → IDLE with edge_cnt←0.
    - Leaving at S+1 (mid stop bit) allows back-to-back frames.
- Decision at STOP edge S+1; the pulse appears on the following cycle:
  - Latched parity flag = 1 → parity_error. Parity takes priority if stp_err is also 1.
  - Otherwise, stp_err = 1 → framing_error.
  - Otherwise → data_valid.
  - Exactly one pulse per completed frame; none for glitch-aborted frames.
- RX_IN low on the first IDLE cycle after STOP starts a new frame immediately. data_valid for the previous frame is still emitted in that same cycle.
- With PAR_EN=0 the parity flag is forced 0 and par_chk_en never asserts.
- Frame length in cycles, from the detection cycle to the pulse cycle inclusive of the STOP stretch: (2+DATA_WIDTH+PAR_EN)·P − P + S + 2. For P=8, PAR_EN=0 that is 80 cycles.

Test Plan:
- P=8, PAR_EN=0, frame 0xA5 with good stop bit, detection at cycle t0:
  - Required: strt_chk_en at t6.
  - Required: deser_en at t14, t22 … t70 (8 pulses).
  - Required: stp_chk_en at t78; data_valid=1 only at t80.
- P=16, PAR_EN=1, frame 0x3C with par_err driven 1 during the parity bit:
  - Required: par_chk_en at the parity bit's edge 10.
  - Required: parity_error pulse; no data_valid.
- P=8, stp_err=1 returned after stp_chk_en:
  - Required: framing_error one cycle, then IDLE.
  - Required: the next frame, started one cycle later, is received normally.
- RX_IN low for 2 cycles (strt_glitch=1 at START end):
  - Required: back to IDLE at edge 7.
  - Required: no enable strobes after strt_chk_en; no output pulse.
- RST asserted during DATA bit 4:
  - Required: immediately IDLE, all outputs 0, no pulse.
  - Required: a fresh frame after release decodes correctly.
- Prescale=12 on the detect cycle, or Prescale changed mid-frame:
  - Required: P=12 is treated as 8 (80-cycle frame).
  - Required: a mid-frame change has no effect until the next start.
